mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the MIPS top level. It snoops the processor's data-memory store bus (memwrite, dataadr, writedata), captures byte stores to one fixed address into a small FIFO, and serializes them on a single TX line as 8N1 frames. It gives the processor a character output channel without stalling the core.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; must be ≥ 2.
- FIFO_DEPTH, default 4: byte FIFO entries; must be a power of 2, ≥ 2.
- TX_ADDR, default 32'hFFFF_FF00: byte address whose stores are captured.

- clk  input  1  rising-edge clock, shared with the processor.
- reset  input  1  asynchronous, active-high reset.
- memwrite  input  1  store strobe from the processor.
- dataadr  input  32  store address.
- writedata  input  32  store data; only bits [7:0] are used.
- txd  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is being shifted out.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte in flight.
- drop_count  output  8  saturating count of stores lost because the FIFO was full.

## Operation
- Push: a push occurs when memwrite && dataadr == TX_ADDR at a rising edge. It enqueues writedata[7:0]. Stores to any other address are ignored.
- FIFO: circular buffer with wrap-around read and write pointers.
  - Push while full with no pop on the same edge: the byte is discarded and drop_count increments, saturating at 255.
  - Push and pop on the same edge while full: the push is accepted and count is unchanged.
  - Push and pop on the same edge while empty: cannot occur, because a pop requires a non-empty FIFO.
- FSM states: IDLE, START, DATA, STOP. A PARITY state is added when parity is configured; see Configuration.
  - IDLE: txd=1. If fifo_count>0, pop the head into the shift register and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shifts 8 bits LSB first, each bit held CLKS_PER_BIT cycles. A 3-bit bit index advances on each bit boundary. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. It reloads to 0 on every state or bit change.
- tx_busy = (state != IDLE).
- txd is driven from a register and is glitch-free.

## Timing
- Reset values: txd=1, tx_busy=0, fifo_count=0, drop_count=0, state IDLE, FIFO pointers 0.
- Reset is asynchronous and may arrive mid-frame. txd returns high immediately, queued bytes are lost, and the counters clear.
- Push at edge N: fifo_count reflects the push after edge N.
- Pop into an idle line: occurs at edge N+1. After that edge, txd=0 and tx_busy=1, and fifo_count has decremented. Latency from an accepted store to the start-bit falling edge is therefore 1 cycle.
- Frame length: exactly 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- Back-to-back frames: the next start bit begins the cycle after the last stop-bit cycle.
- Pushes during a frame are queued and never disturb the frame in flight.

## Configuration
- UART_PARITY_EN
  - Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, making the frame 8E1.
  - Undefined: 8N1 framing and no PARITY state.

## Test plan
- Single byte: after reset, store 32'h0000_0041 to TX_ADDR with CLKS_PER_BIT=4.
  - txd low 1 cycle after the push, for 4 cycles.
  - Then bits 1,0,0,0,0,0,1,0, each held 4 cycles.
  - Then high 4 cycles; tx_busy falls 40 cycles after going high.
- Address filter: a store of 8'h55 to TX_ADDR+4, and a read-cycle access to TX_ADDR with memwrite=0 → fifo_count stays 0 and txd stays 1.
- Overflow: six consecutive stores 8'h01..8'h06 with FIFO_DEPTH=4.
  - The first byte is popped at once, so 4 more are queued and 1 is dropped.
  - drop_count=1, fifo_count=4.
  - Frames carry 01,02,03,04,05 back-to-back with no idle gap.
- Full push+pop: fill the FIFO while a frame is in flight, then push on the exact cycle the stop bit ends → the push is accepted, fifo_count stays 4, drop_count unchanged.
- Mid-frame reset: assert reset during DATA bit 3 → txd=1, tx_busy=0, fifo_count=0 asynchronously. After release, a new store transmits correctly from its start bit.
- Parity (UART_PARITY_EN defined): send 8'h07 → a parity bit of 1 follows bit 7, and the frame is 44 cycles long.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: snoops the processor store bus, queues byte stores to TX_ADDR
// in a small FIFO and serializes them on txd as 8N1 frames (8E1 when the
// UART_PARITY_EN macro is defined).
//
// Parameters: CLKS_PER_BIT (>=2), FIFO_DEPTH (power of 2, >=2), TX_ADDR.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   memwrite        store strobe
//   dataadr         store address
//   writedata       store data, bits [7:0] are queued
//   txd             serial line, idles high
//   tx_busy         high while a frame is on the line
//   fifo_count      bytes queued, excluding the byte in flight
//   drop_count      saturating count of stores lost to a full FIFO
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_ADDR      = 32'hFFFF_FF00
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          memwrite,
  input  logic [31:0]                   dataadr,
  input  logic [31:0]                   writedata,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]      drop_q, drop_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push_c, pop_c, full_c, wr_en_c, baud_end_c;
  logic [7:0]      head_c;

  assign push_c     = memwrite && (dataadr == TX_ADDR);
  assign full_c     = (count_q == DEPTH_C);
  assign head_c     = mem_q[rd_ptr_q];
  assign baud_end_c = (baud_q == BAUD_LAST);

  // Frame sequencer; a pop loads the shift register and latches its parity.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          state_d = S_START;
          baud_d  = '0;
          shift_d = head_c;
          par_d   = ^head_c;
        end
      end
      S_START: begin
        if (baud_end_c) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_end_c) begin
          state_d = S_STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_end_c) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count_q != '0) begin
            pop_c   = 1'b1;
            state_d = S_START;
            shift_d = head_c;
            par_d   = ^head_c;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is a function of the next state so txd comes straight off a flop.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    wr_en_c  = push_c && (!full_c || pop_c);
    count_d  = count_q + CW'(wr_en_c) - CW'(pop_c);
    wr_ptr_d = wr_ptr_q + AW'(wr_en_c);
    rd_ptr_d = rd_ptr_q + AW'(pop_c);
    drop_d   = drop_q;
    if (push_c && full_c && !pop_c && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= writedata[7:0];
    end
  end

  assign txd        = txd_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;
  assign drop_count = drop_q;

endmodule
